fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 124 ++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: write-pointer synchronizer, Gray read pointer, empty/underflow flags.
// Optional fill-level and almost-empty tracking is enabled by defining FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl #(
  parameter int ADDRSIZE      = 9,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic                rinc,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);
  localparam int PW = ADDRSIZE + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  logic [PW-1:0] rq1_r;
  logic [PW-1:0] rq2_r;
  logic [PW-1:0] rbin_r;
  logic [PW-1:0] rgray_r;
  logic [PW-1:0] rbin_next_s;
  logic [PW-1:0] rgray_next_s;
  logic          rempty_r;
  logic          rempty_next_s;
  logic          underflow_r;
  logic          accept_s;

  // Read acceptance, next pointers and next empty flag
  always_comb begin
    accept_s      = rinc & ~rempty_r;
    rbin_next_s   = rbin_r + {{ADDRSIZE{1'b0}}, accept_s};
    rgray_next_s  = bin2gray(rbin_next_s);
    rempty_next_s = (rgray_next_s == rq2_r);
  end

  // Two-flop synchronizer for the Gray write pointer
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq1_r <= {PW{1'b0}};
      rq2_r <= {PW{1'b0}};
    end else begin
      rq1_r <= wptr;
      rq2_r <= rq1_r;
    end
  end

  // Read pointer and empty flag registers
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_r   <= {PW{1'b0}};
      rgray_r  <= {PW{1'b0}};
      rempty_r <= 1'b1;
    end else begin
      rbin_r   <= rbin_next_s;
      rgray_r  <= rgray_next_s;
      rempty_r <= rempty_next_s;
    end
  end

  // Sticky underflow: a read request while empty is never cleared except by reset
  always_ff @(posedge rclk) begin
    if (rrst) begin
      underflow_r <= 1'b0;
    end else if (rinc && rempty_r) begin
      underflow_r <= 1'b1;
    end else begin
      underflow_r <= underflow_r;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_s;
  logic [PW-1:0] level_next_s;
  logic [PW-1:0] rlevel_r;
  logic          aempty_next_s;
  logic          raempty_r;

  // Level uses the post-read pointer so a same-cycle read and write update combine
  always_comb begin
    wbin_s        = gray2bin(rq2_r);
    level_next_s  = wbin_s - rbin_next_s;
    aempty_next_s = (level_next_s <= PW'(AEMPTY_THRESH));
  end

  // Fill level and almost-empty registers
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rlevel_r  <= {PW{1'b0}};
      raempty_r <= 1'b1;
    end else begin
      rlevel_r  <= level_next_s;
      raempty_r <= aempty_next_s;
    end
  end

  assign rlevel  = rlevel_r;
  assign raempty = raempty_r;
`else
  assign rlevel  = {PW{1'b0}};
  assign raempty = rempty_r;
`endif

  assign raddr      = rbin_r[ADDRSIZE-1:0];
  assign rptr       = rgray_r;
  assign rempty     = rempty_r;
  assign runderflow = underflow_r;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl (ADDRSIZE=4, AEMPTY_THRESH=4); expectations follow FIFO_RD_LEVEL_EN.
module tb_fifo_rd_ctrl;
  logic       rclk = 1'b0;
  logic       rrst;
  logic       rinc;
  logic [4:0] wptr;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [4:0] rlevel;
  logic       runderflow;

  fifo_rd_ctrl #(.ADDRSIZE(4), .AEMPTY_THRESH(4)) dut (
    .rclk(rclk), .rrst(rrst), .wptr(wptr), .rinc(rinc),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  typedef logic [16:0] vec_t;
  vec_t exp_q[$];
  vec_t exp_v;
  vec_t obs;
  assign obs = {raddr, rptr, rempty, raempty, rlevel, runderflow};

  int n_cmp = 0;
  int n_err = 0;
  int rb = 0;
  int wb = 0;
  bit unf = 1'b0;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  // Expected outputs once the read pointer is rbin and the synchronized write pointer is wbin
  function automatic vec_t exp_vec(input int rbin, input int wbin, input bit u);
    logic [4:0] b;
    logic [4:0] lv;
    logic [4:0] rl;
    logic       e;
    logic       ae;
    b  = 5'(rbin);
    lv = 5'(wbin - rbin);
    e  = (lv == 5'd0);
`ifdef FIFO_RD_LEVEL_EN
    rl = lv;
    ae = (lv <= 5'd4);
`else
    rl = 5'd0;
    ae = e;
`endif
    return {b[3:0], b ^ (b >> 1), e, ae, rl, u};
  endfunction

  task automatic test_reset();
    rrst = 1'b1; rinc = 1'b1; wptr = 5'd0;
    exp_q.push_back(exp_vec(0, 0, 1'b0));
    @(posedge rclk); #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset: got %h expected %h", obs, exp_v); end
    rrst = 1'b0; rinc = 1'b0; rb = 0; wb = 0; unf = 1'b0;
    exp_q.push_back(exp_vec(0, 0, 1'b0));
    @(posedge rclk); #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_idle: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_latency();
    wptr = gray5(1);
    for (int c = 1; c <= 3; c++) begin
      exp_q.push_back(exp_vec(rb, (c < 3) ? wb : 1, unf));
      @(posedge rclk); #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL latency edge %0d: got %h expected %h", c, obs, exp_v); end
    end
    wb = 1;
  endtask

  task automatic test_drain();
    wptr = gray5(6);
    for (int c = 1; c <= 3; c++) begin
      exp_q.push_back(exp_vec(rb, (c < 3) ? wb : 6, unf));
      @(posedge rclk); #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL drain_sync edge %0d: got %h expected %h", c, obs, exp_v); end
    end
    wb = 6;
    rinc = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      rb++;
      exp_q.push_back(exp_vec(rb, wb, unf));
      @(posedge rclk); #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL drain read %0d: got %h expected %h", i, obs, exp_v); end
    end
    rinc = 1'b0;
  endtask

  task automatic test_wrap();
    int targets[3] = '{22, 30, 46};
    int nreads[3]  = '{16, 8, 16};
    for (int k = 0; k < 3; k++) begin
      wptr = gray5(targets[k]);
      for (int c = 1; c <= 3; c++) begin
        exp_q.push_back(exp_vec(rb, (c < 3) ? wb : targets[k], unf));
        @(posedge rclk); #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_sync %0d/%0d: got %h expected %h", k, c, obs, exp_v); end
      end
      wb = targets[k];
      rinc = 1'b1;
      for (int i = 1; i <= nreads[k]; i++) begin
        rb++;
        exp_q.push_back(exp_vec(rb, wb, unf));
        @(posedge rclk); #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL wrap_read %0d/%0d: got %h expected %h", k, i, obs, exp_v); end
      end
      rinc = 1'b0;
    end
  endtask

  task automatic test_underflow();
    rinc = 1'b1;
    exp_q.push_back(exp_vec(rb, wb, 1'b1));
    @(posedge rclk); #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL underflow_set: got %h expected %h", obs, exp_v); end
    unf = 1'b1;
    rinc = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(exp_vec(rb, wb, unf));
      @(posedge rclk); #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL underflow_hold %0d: got %h expected %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_midreset();
    wptr = gray5(wb + 3);
    repeat (3) @(posedge rclk);
    #1;
    rinc = 1'b1;
    @(posedge rclk); #1;
    rrst = 1'b1;
    exp_q.push_back(exp_vec(0, 0, 1'b0));
    @(posedge rclk); #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL midreset: got %h expected %h", obs, exp_v); end
    rrst = 1'b0; rinc = 1'b0; wptr = 5'd0;
    rb = 0; wb = 0; unf = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(exp_vec(rb, wb, unf));
      @(posedge rclk); #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL midreset_idle %0d: got %h expected %h", i, obs, exp_v); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rrst = 1'b1; rinc = 1'b0; wptr = 5'd0;
    test_reset();
    test_latency();
    test_drain();
    test_wrap();
    test_underflow();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
